long_delay_sched: RTL and testbench

LONG_DELAY_SCHED -- requirements
Module: long_delay_sched

---
 rtl/long_delay_pkg.sv | 23 ++
 rtl/long_delay_addr_ctr.sv | 41 ++++
 rtl/long_delay_sched.sv | 165 ++++++++++++++++
 tb/tb_long_delay_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/long_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module  : long_delay_pkg
// Purpose : Shared types and constants for the long-delay scheduler slice.
//           Holds the scheduler state encoding and the delay/width limits
//           used by long_delay_sched and long_delay_addr_ctr.
// Revision: 1.0 - initial release
// ============================================================================
package long_delay_pkg;

    // Scheduler states; the encoding is visible on state_out.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Smallest delay the read/write schedule supports.
    localparam int MIN_DELAY      = 2;
    localparam int DEFAULT_DATA_W = 16;

endpackage
`default_nettype wire

// File: rtl/long_delay_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module  : long_delay_addr_ctr
// Purpose : Modulo-2**ADDR_W address pointer with enable and synchronous
//           clear. Used as the write pointer of the delay line.
// Ports   : clk    - rising-edge clock
//           rst_n  - synchronous active-low reset (pointer -> 0)
//           i_clr  - synchronous clear (pointer -> 0)
//           i_en   - advance pointer by one, wrapping DEPTH-1 -> 0
//           o_ptr  - current pointer value
// Revision: 1.0 - initial release
// ============================================================================
module long_delay_addr_ctr
    import long_delay_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;

    // DEPTH is a power of two, so natural overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/long_delay_sched.sv
`default_nettype none
// ============================================================================
// Module  : long_delay_sched
// Purpose : Programmable long delay line built around an external 1R1W SRAM
//           with 1-cycle read latency. A sample written in enabled cycle k
//           is loaded onto data_out (valid_out=1) at the end of enabled
//           cycle k+D, D = clamp(cfg_delay, 2, DEPTH) latched on flush.
// Ports   : clk, rst_n (sync, active-low), flush, clk_en, cfg_delay, data_in
//           SRAM write side : sram_wen, sram_waddr, sram_wdata
//           SRAM read side  : sram_ren, sram_raddr, sram_rdata
//           Outputs         : data_out, valid_out, state_out
// Options : LONG_DELAY_SCHED_STATS_EN adds sample_cnt (delivered samples,
//           cleared by reset/flush) and overrun (sticky flush-in-STREAM).
// Revision: 1.0 - initial release
// ============================================================================
module long_delay_sched
    import long_delay_pkg::*;
#(
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int ADDR_W        = 9,
    parameter int DEFAULT_DELAY = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              clk_en,
    input  logic [ADDR_W:0]   cfg_delay,
    input  logic [DATA_W-1:0] data_in,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        state_out
`ifdef LONG_DELAY_SCHED_STATS_EN
    ,
    output logic [31:0]       sample_cnt,
    output logic              overrun
`endif
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   c_min_d   = (ADDR_W+1)'(MIN_DELAY);
    localparam logic [ADDR_W:0]   c_max_d   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_rst_dm1 = ADDR_W'(DEFAULT_DELAY - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_dm1;        // latched D-1
    logic [ADDR_W-1:0] r_fill;       // writes since flush, saturates at D-1
    logic              r_rd_pend;    // SRAM read data is on sram_rdata now
    logic              r_data_avail; // a read was issued on the last enabled cycle
    logic [DATA_W-1:0] r_hold;       // copy of read data that arrived in a stall

    logic [ADDR_W:0]   w_d_clamp;
    logic [ADDR_W-1:0] w_dm1_new;
    logic [ADDR_W-1:0] w_wp;
    logic [ADDR_W-1:0] w_fill_inc;
    logic              w_adv;
    logic              w_ren;

    always_comb begin
        w_d_clamp = cfg_delay;
        if (cfg_delay < c_min_d) begin
            w_d_clamp = c_min_d;
        end else if (cfg_delay > c_max_d) begin
            w_d_clamp = c_max_d;
        end
    end

    assign w_dm1_new  = ADDR_W'(w_d_clamp - 1'b1);
    assign w_fill_inc = r_fill + 1'b1;

    // One sample is accepted per enabled, non-flush cycle while active.
    assign w_adv = rst_n & clk_en & ~flush & (r_state != IDLE);
    // Once D-1 samples are stored, every accepted sample triggers a read of
    // the sample written D-1 writes earlier; its data lands one enabled cycle
    // later, giving D enabled cycles end to end.
    assign w_ren = w_adv & (r_fill == r_dm1);

    long_delay_addr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_wp (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_en  (w_adv),
        .o_ptr (w_wp)
    );

    assign sram_wen   = w_adv;
    assign sram_waddr = w_wp;
    assign sram_wdata = data_in;
    assign sram_ren   = w_ren;
    assign sram_raddr = w_ren ? (w_wp - r_dm1) : '0;
    assign state_out  = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dm1        <= c_rst_dm1;
            r_fill       <= '0;
            r_rd_pend    <= 1'b0;
            r_data_avail <= 1'b0;
            r_hold       <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
        end else if (flush) begin
            // Any read in flight belongs to the old stream and is dropped.
            r_state      <= FILL;
            r_dm1        <= w_dm1_new;
            r_fill       <= '0;
            r_rd_pend    <= 1'b0;
            r_data_avail <= 1'b0;
            valid_out    <= 1'b0;
        end else begin
            r_rd_pend <= w_ren;
            // Read data is only on the SRAM bus for one cycle; keep a copy in
            // case that cycle is a stall.
            if (r_rd_pend) begin
                r_hold <= sram_rdata;
            end
            if (w_adv) begin
                if (r_fill != r_dm1) begin
                    r_fill <= w_fill_inc;
                end
                if ((r_state == FILL) && (w_fill_inc == r_dm1)) begin
                    r_state <= STREAM;
                end
                r_data_avail <= w_ren;
                if (r_data_avail) begin
                    data_out  <= r_rd_pend ? sram_rdata : r_hold;
                    valid_out <= 1'b1;
                end
            end
        end
    end

`ifdef LONG_DELAY_SCHED_STATS_EN
    logic [31:0] r_sample_cnt;
    logic        r_overrun;

    // Counts samples delivered on data_out with valid_out=1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
            r_overrun    <= 1'b0;
        end else if (flush) begin
            r_sample_cnt <= '0;
            if (r_state == STREAM) begin
                r_overrun <= 1'b1;
            end
        end else if (w_adv && r_data_avail) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
        end
    end

    assign sample_cnt = r_sample_cnt;
    assign overrun    = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_long_delay_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_long_delay_sched
// Purpose : Self-checking bench for long_delay_sched (default parameters).
//           A behavioural SRAM is attached; expected outputs come from a
//           sample-history model: after n accepted samples since flush the
//           output must be sample n-1-D, valid once n-1 >= D.
// Revision: 1.0 - initial release
// ============================================================================
module tb_long_delay_sched;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              clk_en;
    logic [ADDR_W:0]   cfg_delay;
    logic [DATA_W-1:0] data_in;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_waddr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] sram_rdata;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [1:0]        state_out;
`ifdef LONG_DELAY_SCHED_STATS_EN
    logic [31:0]       sample_cnt;
    logic              overrun;
`endif

    long_delay_sched #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .DEFAULT_DELAY (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .clk_en     (clk_en),
        .cfg_delay  (cfg_delay),
        .data_in    (data_in),
        .sram_wen   (sram_wen),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata),
        .sram_ren   (sram_ren),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .state_out  (state_out)
`ifdef LONG_DELAY_SCHED_STATS_EN
        ,
        .sample_cnt (sample_cnt),
        .overrun    (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, read-before-write on collision.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= mem[sram_raddr];
        if (sram_wen) mem[sram_waddr] <= sram_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    bit                m_idle;
    int                m_d;
    int                m_w;          // samples accepted since flush
    logic [DATA_W-1:0] m_hist[$];
    bit                m_valid;
    logic [DATA_W-1:0] m_data;
    bit                m_lat_seen;

    function automatic int clamp_d(input int c);
        if (c < 2) return 2;
        if (c > DEPTH) return DEPTH;
        return c;
    endfunction

    task automatic do_reset(input logic fl, input logic en);
        @(negedge clk);
        rst_n = 1'b0; flush = fl; clk_en = en; data_in = 16'h5A5A;
        @(posedge clk);
        #1;
        m_idle = 1; m_w = 0; m_valid = 0; m_data = '0; m_hist.delete();
        check_eq("rst_state", 32'(state_out), 32'd0);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_data",  32'(data_out),  32'd0);
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0;
        #1;
        check_eq("rst_wen",   32'(sram_wen),   32'd0);
        check_eq("rst_ren",   32'(sram_ren),   32'd0);
        check_eq("rst_waddr", 32'(sram_waddr), 32'd0);
        check_eq("rst_raddr", 32'(sram_raddr), 32'd0);
    endtask

    task automatic step(input logic fl, input logic en, input logic [DATA_W-1:0] din);
        bit exp_wen;
        bit exp_ren;
        int exp_state;
        @(negedge clk);
        flush = fl; clk_en = en; data_in = din;
        #1;
        exp_wen = en && !fl && !m_idle;
        exp_ren = exp_wen && (m_w >= m_d - 1);
        check_eq("wen", 32'(sram_wen), 32'(exp_wen));
        check_eq("ren", 32'(sram_ren), 32'(exp_ren));
        if (exp_wen) begin
            check_eq("waddr", 32'(sram_waddr), 32'(m_w % DEPTH));
            check_eq("wdata", 32'(sram_wdata), 32'(din));
        end
        if (exp_ren) begin
            check_eq("raddr", 32'(sram_raddr), 32'((m_w - (m_d - 1)) % DEPTH));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            m_idle = 0; m_d = clamp_d(int'(cfg_delay)); m_w = 0;
            m_hist.delete(); m_valid = 0; m_lat_seen = 0;
        end else if (en && !m_idle) begin
            m_hist.push_back(din);
            m_w++;
            if (m_w - 1 >= m_d) begin
                m_valid = 1;
                m_data  = m_hist[m_w - 1 - m_d];
            end
        end
        exp_state = m_idle ? 0 : ((m_w >= m_d - 1) ? 2 : 1);
        check_eq("state", 32'(state_out), 32'(exp_state));
        check_eq("valid", 32'(valid_out), 32'(m_valid));
        if (m_valid) check_eq("data", 32'(data_out), 32'(m_data));
        if (!fl && !m_idle && !m_lat_seen && valid_out) begin
            m_lat_seen = 1;
            check_eq("latency", 32'(m_w - 1), 32'(m_d));
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; clk_en = 1'b0; cfg_delay = '0; data_in = '0;
        m_d = 64; m_lat_seen = 1;

        // Reset wins over flush and clk_en
        do_reset(1'b1, 1'b1);
`ifdef LONG_DELAY_SCHED_STATS_EN
        check_eq("rst_cnt",     sample_cnt,      32'd0);
        check_eq("rst_overrun", 32'(overrun),    32'd0);
`endif
        // IDLE ignores enabled cycles
        step(1'b0, 1'b1, 16'hAAAA);
        step(1'b0, 1'b1, 16'h5555);

        // D=5, ramp 1,2,3...
        cfg_delay = 10'd5;
        step(1'b1, 1'b1, '0);
`ifdef LONG_DELAY_SCHED_STATS_EN
        check_eq("overrun_idle_flush", 32'(overrun), 32'd0);
`endif
        for (int i = 1; i <= 30; i++) step(1'b0, 1'b1, 16'(i));

        // cfg_delay=0 clamps to 2 (flush from STREAM)
        cfg_delay = 10'd0;
        step(1'b1, 1'b1, '0);
        repeat (20) step(1'b0, 1'b1, 16'($urandom));

        // cfg_delay=1000 clamps to 512; long run wraps the write pointer
        cfg_delay = 10'd1000;
        step(1'b1, 1'b1, '0);
        repeat (2000) step(1'b0, 1'b1, 16'($urandom));

        // D=8 with random stalls; flush issued with clk_en low
        cfg_delay = 10'd8;
        step(1'b1, 1'b0, '0);
        repeat (300) step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));

        // Flush mid-STREAM to D=3, again with clk_en low
        cfg_delay = 10'd3;
        step(1'b1, 1'b0, '0);
`ifdef LONG_DELAY_SCHED_STATS_EN
        check_eq("overrun_set", 32'(overrun),  32'd1);
        check_eq("cnt_flush",   sample_cnt,    32'd0);
`endif
        repeat (40) step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));

        // Reset during STREAM
        do_reset(1'b1, 1'b1);
`ifdef LONG_DELAY_SCHED_STATS_EN
        check_eq("overrun_clr", 32'(overrun), 32'd0);
`endif
        step(1'b0, 1'b1, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
